// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the Wishbone initiator and its watchdog.
package wb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  // One extra count of headroom so the counter never wraps before the compare.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Cycle counter that flags the edge on which an unacknowledged bus cycle must be aborted.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int timeout = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = cnt_width(timeout);
  localparam logic [CW-1:0] LAST = CW'(timeout - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples its inputs from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // High during the cycle whose closing edge is the timeout-th edge without ACK.
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator: one host command becomes one CYC/STB cycle.
module wb_master
  import wb_pkg::*;
#(
  parameter int adr_width = 16,
  parameter int mem_width = 16,
  parameter int timeout   = 8
) (
  input  logic                 i_wb_clk,
  input  logic                 i_wb_rst_n,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [adr_width-1:0] i_adr,
  input  logic [mem_width-1:0] i_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [mem_width-1:0] o_rdata,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [adr_width-1:0] o_wb_adr,
  output logic [mem_width-1:0] o_wb_data,
  input  logic                 i_wb_ack,
  input  logic [mem_width-1:0] i_wb_data
);

  state_t               state, state_n;
  logic                 cyc, cyc_n;
  logic                 we, we_n;
  logic [adr_width-1:0] adr, adr_n;
  logic [mem_width-1:0] wdata, wdata_n;
  logic [mem_width-1:0] rdata, rdata_n;
  logic                 done, done_n;
  logic                 err, err_n;
  logic                 wd_enable;
  logic                 wd_expire;

  wb_watchdog #(
    .timeout(timeout)
  ) u_watchdog (
    .clk   (i_wb_clk),
    .rst_n (i_wb_rst_n),
    .clear (state == S_IDLE),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state <= S_IDLE;
      cyc   <= 1'b0;
      we    <= 1'b0;
      adr   <= '0;
      wdata <= '0;
      rdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      we    <= we_n;
      adr   <= adr_n;
      wdata <= wdata_n;
      rdata <= rdata_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    we_n      = we;
    adr_n     = adr;
    wdata_n   = wdata;
    rdata_n   = rdata;
    done_n    = 1'b0;
    err_n     = 1'b0;
    wd_enable = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (i_req) begin
          we_n    = i_we;
          adr_n   = i_adr;
          wdata_n = i_wdata;
          cyc_n   = 1'b1;
          state_n = S_BUS;
        end
      end
      S_BUS: begin
        // ACK takes priority over an expiry landing on the same edge.
        if (i_wb_ack) begin
          cyc_n   = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
          if (!we) rdata_n = i_wb_data;
        end else begin
          wd_enable = 1'b1;
          if (wd_expire) begin
            cyc_n   = 1'b0;
            done_n  = 1'b1;
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign o_busy    = cyc;
  assign o_wb_cyc  = cyc;
  assign o_wb_stb  = cyc;
  assign o_wb_we   = we;
  assign o_wb_adr  = adr;
  assign o_wb_data = wdata;
  assign o_rdata   = rdata;
  assign o_done    = done;
  assign o_err     = err;

endmodule
